// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings, data
// width, reset PC and the target alignment helper.
package fetch_sequencer_pkg;

  localparam int XLEN = 32;

  // Address the ProgramCounter reloads on reset; the first fetch after boot
  // comes from here because nothing in this block drives pc_select in BOOT.
  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT        = 2'd0,
    FS_RUN         = 2'd1,
    FS_REDIR_WAIT  = 2'd2,
    FS_REDIR_ISSUE = 2'd3
  } fs_state_e;

  // Redirect targets are word aligned; the low two bits are always forced to 0.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: redirect sources and imem response in, PC control
// and fetch qualifiers out.
//   master : the sequencer (drives pc_* / flush / valid / state)
//   slave  : the surrounding pipeline (execute, CSR, decode, PC/imem)
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic            imem_resp_valid;
  logic            hazard_stall;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_target;
  logic            trap_redirect;
  logic [XLEN-1:0] trap_vector;
  logic            pc_stall;
  logic            pc_select;
  logic [XLEN-1:0] pc_target;
  logic            flush_fd;
  logic            fetch_valid;
  logic            imem_req_valid;
  logic [1:0]      state;

  modport master (
    input  imem_resp_valid, hazard_stall, ex_redirect, ex_target,
           trap_redirect, trap_vector,
    output pc_stall, pc_select, pc_target, flush_fd, fetch_valid,
           imem_req_valid, state
  );

  modport slave (
    output imem_resp_valid, hazard_stall, ex_redirect, ex_target,
           trap_redirect, trap_vector,
    input  pc_stall, pc_select, pc_target, flush_fd, fetch_valid,
           imem_req_valid, state
  );

endinterface

// File: rtl/fetch_sequencer_redirect_target_latch.sv
// Holds a redirect target while an imem access is still outstanding.
//   clk, reset_n : clock, async active-low reset (clears the target)
//   load_i       : capture target_i (also used for trap overwrite)
//   clear_i      : return to zero once the held target has been issued
//   target_i     : aligned target to capture
//   target_o     : held target
module redirect_target_latch
  import fetch_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] target_q, target_d;

  // A load wins over a clear so a trap landing on the clear cycle is kept.
  always_comb begin
    target_d = target_q;
    if (load_i)       target_d = target_i;
    else if (clear_i) target_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) target_q <= '0;
    else          target_q <= target_d;
  end

  assign target_o = target_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter / instruction fetch sequencer.
// Arbitrates redirects (trap over branch/jump), holds the PC for a boot
// window after reset, defers a redirect that arrives while an imem access is
// outstanding, and generates the fetch/decode flush and fetch-valid qualifiers.
//   clk, reset_n : clock, async active-low reset
//   fs (master)  : imem_resp_valid, hazard_stall, ex_redirect/ex_target,
//                  trap_redirect/trap_vector in; pc_stall, pc_select,
//                  pc_target, flush_fd, fetch_valid, imem_req_valid, state out
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int BOOT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  fetch_sequencer_if.master  fs
);

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  fs_state_e       state_q, state_d;
  logic [CW-1:0]   boot_cnt_q, boot_cnt_d;
  logic            held_load, held_clear;
  logic [XLEN-1:0] held_din, held_target;

  logic            redir;
  logic [XLEN-1:0] redir_tgt;

  logic            pc_stall, pc_select, flush_fd, fetch_valid;
  logic [XLEN-1:0] pc_target;

  assign redir     = fs.trap_redirect | fs.ex_redirect;
  assign redir_tgt = align_pc(fs.trap_redirect ? fs.trap_vector : fs.ex_target);

  redirect_target_latch u_held (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (held_load),
    .clear_i  (held_clear),
    .target_i (held_din),
    .target_o (held_target)
  );

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_stall    = 1'b1;
    pc_select   = 1'b0;
    pc_target   = '0;
    flush_fd    = 1'b1;
    fetch_valid = 1'b0;
    held_load   = 1'b0;
    held_clear  = 1'b0;
    held_din    = redir_tgt;

    unique case (state_q)
      // Redirects are ignored here; the PC comes up from its own reset value.
      FS_BOOT: begin
        if (boot_cnt_q == CW'(BOOT_CYCLES - 1)) begin
          state_d    = FS_RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + CW'(1);
        end
      end

      FS_RUN: begin
        if (redir && fs.imem_resp_valid) begin
          // Zero-latency redirect; also flushes any hazard-stalled instruction.
          pc_stall  = 1'b0;
          pc_select = 1'b1;
          pc_target = redir_tgt;
        end else if (redir) begin
          // Access in flight: park the target until the response drains.
          held_load = 1'b1;
          state_d   = FS_REDIR_WAIT;
        end else begin
          pc_stall    = fs.hazard_stall | ~fs.imem_resp_valid;
          flush_fd    = 1'b0;
          fetch_valid = fs.imem_resp_valid & ~fs.hazard_stall;
        end
      end

      // Branches here are shadow-path bubbles; only a trap may retarget.
      FS_REDIR_WAIT: begin
        held_load = fs.trap_redirect;
        held_din  = align_pc(fs.trap_vector);
        if (fs.imem_resp_valid) state_d = FS_REDIR_ISSUE;
      end

      FS_REDIR_ISSUE: begin
        pc_stall   = 1'b0;
        pc_select  = 1'b1;
        pc_target  = fs.trap_redirect ? align_pc(fs.trap_vector) : held_target;
        held_clear = 1'b1;
        state_d    = FS_RUN;
      end

      default: state_d = FS_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FS_BOOT;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  assign fs.pc_stall       = pc_stall;
  assign fs.pc_select      = pc_select;
  assign fs.pc_target      = pc_target;
  assign fs.flush_fd       = flush_fd;
  assign fs.fetch_valid    = fetch_valid;
  assign fs.imem_req_valid = ~pc_stall & (state_q != FS_BOOT);
  assign fs.state          = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Inputs change 1 time unit after the
// rising edge; outputs are compared 2 units later, before the next edge.
// Compared vector layout: {pc_stall, pc_select, flush_fd, fetch_valid,
// imem_req_valid, state[1:0]}.
module tb_fetch_sequencer;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  fetch_sequencer_if fs ();

  fetch_sequencer #(.BOOT_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fs      (fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {fs.pc_stall, fs.pc_select, fs.flush_fd, fs.fetch_valid,
            fs.imem_req_valid, fs.state};
  endfunction

  // stall and select must never be asserted together
  always @(negedge clk) begin
    checks++;
    if (fs.pc_stall && fs.pc_select) begin
      errors++;
      $display("FAIL invariant: pc_stall=%b pc_select=%b at %0t exp not both 1",
               fs.pc_stall, fs.pc_select, $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fs.imem_resp_valid = 1'b0;
    fs.hazard_stall    = 1'b0;
    fs.ex_redirect     = 1'b0;
    fs.ex_target       = '0;
    fs.trap_redirect   = 1'b0;
    fs.trap_vector     = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      checks++;
      if (obs() !== 7'b1010000 || fs.pc_target !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b/%h exp 1010000/00000000", i, obs(), fs.pc_target);
      end
    end
    step();
    reset_n = 1'b1;
    fs.imem_resp_valid = 1'b1;
    #2;
    checks++;
    if (obs() !== 7'b1010000) begin
      errors++;
      $display("FAIL boot_cyc0: got %b exp 1010000", obs());
    end
    step();
    fs.ex_redirect = 1'b1;
    fs.ex_target   = 32'h0000_1234;
    #2;
    checks++;
    if (obs() !== 7'b1010000 || fs.pc_target !== 32'h0) begin
      errors++;
      $display("FAIL boot_cyc1_ignore_redir: got %b/%h exp 1010000/00000000", obs(), fs.pc_target);
    end
    step();
    fs.ex_redirect = 1'b0;
    #2;
    checks++;
    if (obs() !== 7'b0001101) begin
      errors++;
      $display("FAIL boot_to_run: got %b exp 0001101", obs());
    end
  endtask

  task automatic test_redirect_hit();
    step();
    fs.imem_resp_valid = 1'b1;
    fs.ex_redirect     = 1'b1;
    fs.ex_target       = 32'h0000_2043;
    #2;
    checks++;
    if (obs() !== 7'b0110101 || fs.pc_target !== 32'h0000_2040) begin
      errors++;
      $display("FAIL redir_hit: got %b/%h exp 0110101/00002040", obs(), fs.pc_target);
    end
    // trap beats branch in the same cycle
    fs.trap_redirect = 1'b1;
    fs.trap_vector   = 32'h0000_0107;
    #1;
    checks++;
    if (obs() !== 7'b0110101 || fs.pc_target !== 32'h0000_0104) begin
      errors++;
      $display("FAIL trap_priority: got %b/%h exp 0110101/00000104", obs(), fs.pc_target);
    end
    step();
    idle_inputs();
    fs.imem_resp_valid = 1'b1;
    #2;
    checks++;
    if (obs() !== 7'b0001101 || fs.pc_target !== 32'h0) begin
      errors++;
      $display("FAIL run_after_hit: got %b/%h exp 0001101/00000000", obs(), fs.pc_target);
    end
  endtask

  // Miss redirect, three WAIT cycles; trap_at (1..3, 0 = none) injects a trap.
  task automatic test_redirect_wait(input int trap_at, input logic [31:0] exp_tgt);
    step();
    idle_inputs();
    fs.ex_redirect = 1'b1;
    fs.ex_target   = 32'h0000_3000;
    #2;
    checks++;
    if (obs() !== 7'b1010001 || fs.pc_target !== 32'h0) begin
      errors++;
      $display("FAIL redir_miss_run: got %b/%h exp 1010001/00000000", obs(), fs.pc_target);
    end
    for (int w = 1; w <= 3; w++) begin
      step();
      idle_inputs();
      fs.imem_resp_valid = (w == 3);
      if (w == 2) begin
        fs.ex_redirect = 1'b1;            // must be ignored while waiting
        fs.ex_target   = 32'h0000_5000;
      end
      if (w == trap_at) begin
        fs.trap_redirect = 1'b1;
        fs.trap_vector   = 32'h0000_0100;
      end
      #2;
      checks++;
      if (obs() !== 7'b1010010 || fs.pc_target !== 32'h0) begin
        errors++;
        $display("FAIL redir_wait[%0d]: got %b/%h exp 1010010/00000000", w, obs(), fs.pc_target);
      end
    end
    step();
    idle_inputs();
    fs.imem_resp_valid = 1'b1;
    #2;
    checks++;
    if (obs() !== 7'b0110111 || fs.pc_target !== exp_tgt) begin
      errors++;
      $display("FAIL redir_issue: got %b/%h exp 0110111/%h", obs(), fs.pc_target, exp_tgt);
    end
    step();
    #2;
    checks++;
    if (obs() !== 7'b0001101) begin
      errors++;
      $display("FAIL run_after_issue: got %b exp 0001101", obs());
    end
  endtask

  task automatic test_trap_in_issue();
    step();
    idle_inputs();
    fs.ex_redirect = 1'b1;
    fs.ex_target   = 32'h0000_4000;
    step();
    idle_inputs();
    fs.imem_resp_valid = 1'b1;
    step();
    fs.trap_redirect = 1'b1;
    fs.trap_vector   = 32'h0000_0203;
    #2;
    checks++;
    if (obs() !== 7'b0110111 || fs.pc_target !== 32'h0000_0200) begin
      errors++;
      $display("FAIL trap_in_issue: got %b/%h exp 0110111/00000200", obs(), fs.pc_target);
    end
    step();
    idle_inputs();
    fs.imem_resp_valid = 1'b1;
  endtask

  task automatic test_hazard();
    step();
    fs.imem_resp_valid = 1'b1;
    fs.hazard_stall    = 1'b1;
    fs.ex_redirect     = 1'b1;
    fs.ex_target       = 32'h0000_2080;
    #2;
    checks++;
    if (obs() !== 7'b0110101 || fs.pc_target !== 32'h0000_2080) begin
      errors++;
      $display("FAIL hazard_vs_redir: got %b/%h exp 0110101/00002080", obs(), fs.pc_target);
    end
    step();
    fs.ex_redirect = 1'b0;
    #2;
    checks++;
    if (obs() !== 7'b1000001 || fs.pc_target !== 32'h0) begin
      errors++;
      $display("FAIL hazard_only: got %b/%h exp 1000001/00000000", obs(), fs.pc_target);
    end
    step();
    fs.hazard_stall    = 1'b0;
    fs.imem_resp_valid = 1'b0;
    #2;
    checks++;
    if (obs() !== 7'b1000001) begin
      errors++;
      $display("FAIL resp_pending: got %b exp 1000001", obs());
    end
  endtask

  task automatic test_reset_mid_wait();
    step();
    idle_inputs();
    fs.ex_redirect = 1'b1;
    fs.ex_target   = 32'h0000_6000;
    step();
    idle_inputs();
    #2;
    checks++;
    if (obs() !== 7'b1010010) begin
      errors++;
      $display("FAIL pre_reset_wait: got %b exp 1010010", obs());
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 7'b1010000 || fs.pc_target !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got %b/%h exp 1010000/00000000", obs(), fs.pc_target);
    end
    step();
    fs.imem_resp_valid = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (obs() !== 7'b0001101 || fs.pc_target !== 32'h0) begin
        errors++;
        $display("FAIL post_reset_run[%0d]: got %b/%h exp 0001101/00000000", i, obs(), fs.pc_target);
      end
      step();
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_redirect_hit();
    test_redirect_wait(0, 32'h0000_3000);
    test_redirect_wait(2, 32'h0000_0100);
    test_trap_in_issue();
    test_hazard();
    test_reset_mid_wait();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
